// File: rtl/ccd_gray_pkg.sv
// Shared widths, default luma weights and frame-monitor state encoding for the
// CCD gray packer.
package ccd_gray_pkg;

  localparam int W_IN     = 12;
  localparam int W_OUT    = 10;
  localparam int W_SUM    = 19;
  localparam int W_CNT    = 19;
  localparam int PIPE_LAT = 3;

  localparam int COEF_R_DEF = 27;
  localparam int COEF_G_DEF = 91;
  localparam int COEF_B_DEF = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } frame_state_e;

endpackage

// File: rtl/ccd_frame_monitor.sv
// Frame boundary monitor: counts output pixels between iFVAL edges, lets the
// luma pipeline drain, then publishes the final count and an error flag.
module ccd_frame_monitor
  import ccd_gray_pkg::*;
#(
  parameter int EXP_PIXELS = 307200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dval,
  input  logic             fval,
  output logic [W_CNT-1:0] pix_cnt,
  output logic             frame_done,
  output logic             frame_err,
  output frame_state_e     state
);

  localparam logic [1:0]       DRAIN_LEN = 2'(PIPE_LAT);
  localparam logic [W_CNT-1:0] EXP_CNT   = W_CNT'(EXP_PIXELS);

  frame_state_e     state_n;
  logic             fval_q;
  logic [W_CNT-1:0] cnt_n, cnt_inc;
  logic [1:0]       drain, drain_n;
  logic             done_n, err_n;

  // fval_q resets high so a frame already running at reset release is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fval_q     <= 1'b1;
      pix_cnt    <= '0;
      drain      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      fval_q     <= fval;
      pix_cnt    <= cnt_n;
      drain      <= drain_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  assign cnt_inc = (pix_cnt == '1) ? pix_cnt : pix_cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = pix_cnt;
    drain_n = drain;
    done_n  = 1'b0;
    err_n   = frame_err;
    case (state)
      IDLE: begin
        if (fval && !fval_q) begin
          cnt_n   = '0;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (dval) cnt_n = cnt_inc;
        if (!fval && fval_q) begin
          state_n = DRAIN;
          drain_n = DRAIN_LEN;
        end
      end
      DRAIN: begin
        // Pixels still in the luma pipeline at the iFVAL fall are counted here.
        if (dval) cnt_n = cnt_inc;
        drain_n = drain - 2'd1;
        if (drain == 2'd1) begin
          done_n  = 1'b1;
          err_n   = (cnt_n != EXP_CNT);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/ccd_gray_packer.sv
// RGB-to-luma pipeline (multiply, sum, scale/binarise) feeding the two SDRAM
// write words, plus the per-frame pixel count monitor.
module ccd_gray_packer
  import ccd_gray_pkg::*;
#(
  parameter int EXP_PIXELS = 307200,
  parameter int COEF_R     = COEF_R_DEF,
  parameter int COEF_G     = COEF_G_DEF,
  parameter int COEF_B     = COEF_B_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [W_IN-1:0]   iRed,
  input  logic [W_IN-1:0]   iGreen,
  input  logic [W_IN-1:0]   iBlue,
  input  logic              iDVAL,
  input  logic              iFVAL,
  input  logic              iBIN_EN,
  input  logic [W_OUT-1:0]  iTHRESH,
  output logic [W_OUT-1:0]  oGRAY,
  output logic [15:0]       oWR1_DATA,
  output logic [15:0]       oWR2_DATA,
  output logic              oDVAL,
  output logic [W_CNT-1:0]  oPIX_CNT,
  output logic              oFRAME_DONE,
  output logic              oFRAME_ERR,
  output logic [1:0]        oSTATE
);

  localparam logic [W_SUM-1:0] CR = W_SUM'(COEF_R);
  localparam logic [W_SUM-1:0] CG = W_SUM'(COEF_G);
  localparam logic [W_SUM-1:0] CB = W_SUM'(COEF_B);

  logic [W_SUM-1:0] p_r, p_g, p_b, sum;
  logic             dv1, dv2;
  logic [W_OUT-1:0] g_raw, g_next;
  frame_state_e     fsm_state;

  // Dropping the 9 LSBs divides by 512; weights sum to at most 127.
  assign g_raw  = W_OUT'(sum >> 9);
  assign g_next = iBIN_EN ? ((g_raw >= iTHRESH) ? '1 : '0) : g_raw;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      p_r       <= '0;
      p_g       <= '0;
      p_b       <= '0;
      sum       <= '0;
      dv1       <= 1'b0;
      dv2       <= 1'b0;
      oDVAL     <= 1'b0;
      oGRAY     <= '0;
      oWR1_DATA <= '0;
      oWR2_DATA <= '0;
    end else begin
      p_r   <= W_SUM'(iRed) * CR;
      p_g   <= W_SUM'(iGreen) * CG;
      p_b   <= W_SUM'(iBlue) * CB;
      sum   <= p_r + p_g + p_b;
      dv1   <= iDVAL;
      dv2   <= dv1;
      oDVAL <= dv2;
      // Output stage only loads on a valid pixel so idle cycles hold the last word.
      if (dv2) begin
        oGRAY     <= g_next;
        oWR1_DATA <= {1'b0, g_next[9:5], g_next};
        oWR2_DATA <= {1'b0, g_next[4:0], g_next};
      end
    end
  end

  ccd_frame_monitor #(
    .EXP_PIXELS(EXP_PIXELS)
  ) u_frame_monitor (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .dval      (oDVAL),
    .fval      (iFVAL),
    .pix_cnt   (oPIX_CNT),
    .frame_done(oFRAME_DONE),
    .frame_err (oFRAME_ERR),
    .state     (fsm_state)
  );

  assign oSTATE = fsm_state;

endmodule

// File: tb/tb_ccd_gray_packer.sv
// Bench for ccd_gray_packer: directed luma/binarisation points, random pixel
// bursts and short frames against an arithmetic reference model.
module tb_ccd_gray_packer;

  localparam int EXP = 200;

  logic        iCLK, iRST_N;
  logic [11:0] iRed, iGreen, iBlue;
  logic        iDVAL, iFVAL, iBIN_EN;
  logic [9:0]  iTHRESH;
  logic [9:0]  oGRAY;
  logic [15:0] oWR1_DATA, oWR2_DATA;
  logic        oDVAL;
  logic [18:0] oPIX_CNT;
  logic        oFRAME_DONE, oFRAME_ERR;
  logic [1:0]  oSTATE;

  int errors = 0;
  int checks = 0;

  // Scoreboard: {dval, unbinarised luma} of each driven cycle.
  logic [10:0] exp_q[$];
  logic [9:0]  exp_gray;
  logic        exp_dv;
  logic        model_active, model_err, prev_fv;
  int          model_cnt, age;

  ccd_gray_packer #(.EXP_PIXELS(EXP)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iDVAL(iDVAL), .iFVAL(iFVAL), .iBIN_EN(iBIN_EN), .iTHRESH(iTHRESH),
    .oGRAY(oGRAY), .oWR1_DATA(oWR1_DATA), .oWR2_DATA(oWR2_DATA), .oDVAL(oDVAL),
    .oPIX_CNT(oPIX_CNT), .oFRAME_DONE(oFRAME_DONE), .oFRAME_ERR(oFRAME_ERR),
    .oSTATE(oSTATE)
  );

  // Clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    #1;
    chk("rst_dval", 32'(oDVAL), 0);
    chk("rst_gray", 32'(oGRAY), 0);
    chk("rst_wr1", 32'(oWR1_DATA), 0);
    chk("rst_wr2", 32'(oWR2_DATA), 0);
    chk("rst_cnt", 32'(oPIX_CNT), 0);
    chk("rst_done", 32'(oFRAME_DONE), 0);
    chk("rst_err", 32'(oFRAME_ERR), 0);
    chk("rst_state", 32'(oSTATE), 0);
    @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
    exp_q.delete();
    exp_q.push_back(11'd0);
    exp_q.push_back(11'd0);
    exp_gray = '0;
    exp_dv = 1'b0;
    model_active = 1'b0;
    model_err = 1'b0;
    model_cnt = 0;
    prev_fv = 1'b1;
    age = -1;
  endtask

  // Drive one cycle, advance one clock, and compare against the model.
  task automatic cycle(input logic dv, input logic [11:0] r, input logic [11:0] g,
                       input logic [11:0] b, input logic fv);
    int s;
    logic [10:0] e;
    logic [9:0] lum;
    if (fv && !prev_fv && age < 0) begin
      model_active = 1'b1;
      model_cnt = 0;
    end else if (!fv && prev_fv && model_active) begin
      model_active = 1'b0;
      age = 0;
    end
    if (model_active && fv && dv) model_cnt++;
    prev_fv = fv;
    iDVAL = dv; iRed = r; iGreen = g; iBlue = b; iFVAL = fv;
    s = int'(r) * 27 + int'(g) * 91 + int'(b) * 9;
    lum = 10'(s / 512);
    @(posedge iCLK);
    #1;
    exp_q.push_back({dv, lum});
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      exp_dv = e[10];
      if (e[10]) exp_gray = iBIN_EN ? ((e[9:0] >= iTHRESH) ? 10'd1023 : 10'd0) : e[9:0];
      chk("dval", 32'(oDVAL), 32'(exp_dv));
      chk("gray", 32'(oGRAY), 32'(exp_gray));
      chk("wr1", 32'(oWR1_DATA), (int'(exp_gray) / 32) * 1024 + int'(exp_gray));
      chk("wr2", 32'(oWR2_DATA), (int'(exp_gray) % 32) * 1024 + int'(exp_gray));
    end
    chk("frame_done", 32'(oFRAME_DONE), 32'(age == 3));
    if (age == 3) begin
      chk("pix_cnt", 32'(oPIX_CNT), 32'(model_cnt));
      model_err = (model_cnt != EXP);
      age = -1;
    end else if (age >= 0) begin
      age++;
    end
    chk("frame_err", 32'(oFRAME_ERR), 32'(model_err));
  endtask

  task automatic idle(input int n, input logic fv);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'd0, 12'd0, 12'd0, fv);
  endtask

  task automatic rnd_pixel(input logic fv);
    cycle(1'b1, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
          12'($urandom_range(0, 4095)), fv);
  endtask

  task automatic pixels_in_frame(input int n);
    int sent;
    sent = 0;
    while (sent < n) begin
      if ($urandom_range(0, 4) == 0) cycle(1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
      else begin
        rnd_pixel(1'b1);
        sent++;
      end
    end
  endtask

  task automatic run_frame(input int n);
    idle(3, 1'b0);
    idle(1, 1'b1);
    pixels_in_frame(n);
    idle(6, 1'b0);
  endtask

  initial begin
    iRST_N = 1'b0;
    iRed = '0; iGreen = '0; iBlue = '0;
    iDVAL = 1'b0; iFVAL = 1'b0; iBIN_EN = 1'b0; iTHRESH = '0;
    repeat (2) @(posedge iCLK);
    do_reset();

    // Full-scale pixel
    cycle(1'b1, 12'd4095, 12'd4095, 12'd4095, 1'b0);
    idle(2, 1'b0);
    chk("max_gray", 32'(oGRAY), 1015);
    chk("max_wr1", 32'(oWR1_DATA), 32'h7FF7);
    chk("max_wr2", 32'(oWR2_DATA), 32'h5FF7);
    chk("max_dval", 32'(oDVAL), 1);
    idle(1, 1'b0);
    chk("hold_gray", 32'(oGRAY), 1015);

    // Red only: 1000*27 = 27000 -> 52
    cycle(1'b1, 12'd1000, 12'd0, 12'd0, 1'b0);
    idle(2, 1'b0);
    chk("red_gray", 32'(oGRAY), 52);
    iBIN_EN = 1'b1; iTHRESH = 10'd52;
    cycle(1'b1, 12'd1000, 12'd0, 12'd0, 1'b0);
    idle(2, 1'b0);
    chk("bin_ge", 32'(oGRAY), 32'h3FF);
    iTHRESH = 10'd53;
    cycle(1'b1, 12'd1000, 12'd0, 12'd0, 1'b0);
    idle(2, 1'b0);
    chk("bin_lt", 32'(oGRAY), 0);

    // iDVAL toggling, first plain then binarised with a random threshold
    iBIN_EN = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) rnd_pixel(1'b0);
      else idle(1, 1'b0);
    end
    iBIN_EN = 1'b1; iTHRESH = 10'($urandom_range(100, 900));
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) rnd_pixel(1'b0);
      else idle(1, 1'b0);
    end
    idle(3, 1'b0);
    iBIN_EN = 1'b0;

    // Frames: correct, one short, correct again
    run_frame(EXP);
    chk("cnt_hold", 32'(oPIX_CNT), EXP);
    run_frame(EXP - 1);
    chk("err_short", 32'(oFRAME_ERR), 1);
    run_frame(EXP);
    chk("err_clear", 32'(oFRAME_ERR), 0);

    // Reset in the middle of a frame: that frame must produce no done pulse
    idle(3, 1'b0);
    idle(1, 1'b1);
    pixels_in_frame(100);
    do_reset();
    pixels_in_frame(50);
    idle(6, 1'b0);
    run_frame(EXP);
    chk("post_rst_cnt", 32'(oPIX_CNT), EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
